// File: rtl/control_sequencer.sv
// control_sequencer: microcode sequencer for the 8-bit bus CPU.
// Holds the T-step counter, opcode shadow, flags and halt latch, and drives a
// registered 16-bit control word that is decoded from the *next* step, opcode
// and flags so that ctrl and step always change on the same edge.
// Optional build macro: SEQ_EARLY_END_EN -- when defined, a step whose decoded
// word is empty (and is past fetch) is skipped by restarting at fetch T0.
module control_sequencer #(
  parameter int unsigned MAX_STEPS = 5,
  parameter int unsigned STEP_W    = 3
) (
  input  logic              system_clock,
  input  logic              clr,
  input  logic              step_en,
  input  logic [3:0]        bus_hi,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic [15:0]       ctrl,
  output logic [STEP_W-1:0] step,
  output logic [1:0]        flags,
  output logic              halted
);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [15:0] W_FETCH0 = C_CO | C_MI;
  localparam logic [15:0] W_FETCH1 = C_RO | C_II | C_CE;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  logic [STEP_W-1:0] step_q, step_d;
  logic [15:0]       ctrl_q, ctrl_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        flags_q, flags_d;
  logic              halted_q, halted_d;

  logic [STEP_W-1:0] step_nx;
  logic [15:0]       word_nx;
  logic [3:0]        op_nx;
  logic [1:0]        flags_nx;
  logic              advance;

  // Microcode ROM: control word for a given step, opcode and flags.
  function automatic logic [15:0] decode(input logic [31:0] s,
                                         input logic [3:0]  op,
                                         input logic [1:0]  fl);
    logic [15:0] w;
    w = '0;
    case (s)
      32'd0: w = W_FETCH0;
      32'd1: w = W_FETCH1;
      32'd2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w = C_IO | C_MI;
          OP_LDI: w = C_IO | C_AI;
          OP_JMP: w = C_IO | C_J;
          OP_JC:  w = fl[1] ? (C_IO | C_J) : '0;
          OP_JZ:  w = fl[0] ? (C_IO | C_J) : '0;
          OP_OUT: w = C_AO | C_OI;
          OP_HLT: w = C_HLT;
          default: w = '0;
        endcase
      end
      32'd3: begin
        case (op)
          OP_LDA:         w = C_RO | C_AI;
          OP_ADD, OP_SUB: w = C_RO | C_BI;
          OP_STA:         w = C_AO | C_RI;
          default:        w = '0;
        endcase
      end
      32'd4: begin
        case (op)
          OP_ADD:  w = C_EO | C_AI | C_FI;
          OP_SUB:  w = C_EO | C_AI | C_SU | C_FI;
          default: w = '0;
        endcase
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  // Next-state decode: the word is computed from next step/opcode/flags and
  // registered alongside step; everything holds unless stepping and not halted.
  always_comb begin
    op_nx    = ctrl_q[10] ? bus_hi : op_q;
    flags_nx = ctrl_q[0] ? {alu_carry, alu_zero} : flags_q;
    step_nx  = (step_q == LAST_STEP) ? '0 : step_q + STEP_W'(1);
    word_nx  = decode(32'(step_nx), op_nx, flags_nx);
`ifdef SEQ_EARLY_END_EN
    if ((word_nx == '0) && (step_nx >= STEP_W'(2))) begin
      step_nx = '0;
      word_nx = W_FETCH0;
    end
`endif
    advance  = step_en && !halted_q;

    step_d   = step_q;
    ctrl_d   = ctrl_q;
    op_d     = op_q;
    flags_d  = flags_q;
    halted_d = halted_q;
    if (advance) begin
      step_d   = step_nx;
      ctrl_d   = word_nx;
      op_d     = op_nx;
      flags_d  = flags_nx;
      halted_d = word_nx[15];
    end
  end

  // State registers with asynchronous clear back to fetch T0.
  always_ff @(posedge system_clock or posedge clr) begin
    if (clr) begin
      step_q   <= '0;
      ctrl_q   <= W_FETCH0;
      op_q     <= '0;
      flags_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      ctrl_q   <= ctrl_d;
      op_q     <= op_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
    end
  end

  assign ctrl   = ctrl_q;
  assign step   = step_q;
  assign flags  = flags_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer.
// Stimulus pushes expected {step, ctrl, flags, halted} tagged with the cycle
// they are due; a monitor pops and compares them on the falling clock edge.
module tb_control_sequencer;

  localparam int MAX_STEPS = 5;
  localparam int STEP_W    = 3;

  logic              clk;
  logic              clr;
  logic              step_en;
  logic [3:0]        bus_hi;
  logic              alu_carry;
  logic              alu_zero;
  logic [15:0]       ctrl;
  logic [STEP_W-1:0] step;
  logic [1:0]        flags;
  logic              halted;

  control_sequencer #(.MAX_STEPS(MAX_STEPS), .STEP_W(STEP_W)) dut (
    .system_clock(clk),
    .clr(clr),
    .step_en(step_en),
    .bus_hi(bus_hi),
    .alu_carry(alu_carry),
    .alu_zero(alu_zero),
    .ctrl(ctrl),
    .step(step),
    .flags(flags),
    .halted(halted)
  );

  typedef struct {
    int          due;
    string       tag;
    logic [2:0]  st;
    logic [15:0] cw;
    logic [1:0]  fl;
    logic        hl;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  event imm_ev;

  // reference model state
  int          m_step;
  logic [15:0] m_ctrl;
  logic [3:0]  m_op;
  logic [1:0]  m_fl;
  logic        m_halt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  // Microprogram: fetch words, then up to three execute words per opcode.
  function automatic logic [15:0] ref_word(input logic [3:0] op, input int s,
                                           input logic [1:0] fl);
    logic [47:0] prog;
    prog = '0;
    if (s == 0) return 16'h4004;
    if (s == 1) return 16'h1408;
    case (op)
      4'h1: prog = {16'h0000, 16'h1200, 16'h4800};
      4'h2: prog = {16'h0281, 16'h1020, 16'h4800};
      4'h3: prog = {16'h02C1, 16'h1020, 16'h4800};
      4'h4: prog = {16'h0000, 16'h2100, 16'h4800};
      4'h5: prog = {32'h0, 16'h0A00};
      4'h6: prog = {32'h0, 16'h0802};
      4'h7: prog = {32'h0, (fl[1] ? 16'h0802 : 16'h0000)};
      4'h8: prog = {32'h0, (fl[0] ? 16'h0802 : 16'h0000)};
      4'hE: prog = {32'h0, 16'h0110};
      4'hF: prog = {32'h0, 16'h8000};
      default: prog = '0;
    endcase
    if (s - 2 > 2) return 16'h0000;
    return prog[(s-2)*16 +: 16];
  endfunction

  task automatic model_reset();
    m_step = 0; m_ctrl = 16'h4004; m_op = 4'h0; m_fl = 2'b00; m_halt = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] b, input logic c, input logic z);
    int          ns;
    logic [15:0] w;
    if (m_halt) return;
    if (m_ctrl[10]) m_op = b;
    if (m_ctrl[0])  m_fl = {c, z};
    ns = (m_step + 1) % MAX_STEPS;
    w  = ref_word(m_op, ns, m_fl);
`ifdef SEQ_EARLY_END_EN
    if (w == 16'h0000 && ns >= 2) begin
      ns = 0;
      w  = 16'h4004;
    end
`endif
    m_step = ns;
    m_ctrl = w;
    if (w[15]) m_halt = 1'b1;
  endtask

  task automatic push_c(input int due, input string tag, input int st,
                        input logic [15:0] cw, input logic [1:0] fl, input logic hl);
    exp_t e;
    e.due = due; e.tag = tag; e.st = 3'(st); e.cw = cw; e.fl = fl; e.hl = hl;
    q.push_back(e);
  endtask

  task automatic push_model(input int due, input string tag);
    push_c(due, tag, m_step, m_ctrl, m_fl, m_halt);
  endtask

  // Called at posedge+1; leaves at the following posedge+1.
  task automatic tick(input logic en, input logic [3:0] b, input logic c, input logic z);
    step_en = en; bus_hi = b; alu_carry = c; alu_zero = z;
    if (en) model_step(b, c, z);
    push_model(cyc + 1, "model");
    @(posedge clk); #1;
    step_en = 1'b0;
  endtask

  task automatic tick_x(input logic en, input logic [3:0] b, input logic c, input logic z,
                        input string tag, input int st, input logic [15:0] cw,
                        input logic [1:0] fl, input logic hl);
    push_c(cyc + 1, tag, st, cw, fl, hl);
    tick(en, b, c, z);
  endtask

  // Asynchronous clear mid-cycle: checked immediately, then again after an edge.
  task automatic do_reset();
    @(negedge clk); #2;
    clr = 1'b1;
    #1;
    model_reset();
    push_c(cyc, "clr_async", 0, 16'h4004, 2'b00, 1'b0);
    push_model(cyc, "clr_model");
    -> imm_ev;
    push_model(cyc + 1, "clr_held");
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or imm_ev);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        n_vec++;
        if (step !== e.st || ctrl !== e.cw || flags !== e.fl || halted !== e.hl) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got step=%0d ctrl=%h flags=%b halted=%b, want step=%0d ctrl=%h flags=%b halted=%b",
                   e.tag, cyc, step, ctrl, flags, halted, e.st, e.cw, e.fl, e.hl);
        end
      end
    end
  end

  initial begin
    int          st1 [5];
    logic [15:0] cw1 [5];

    clr = 1'b1; step_en = 1'b0; bus_hi = '0; alu_carry = 1'b0; alu_zero = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // LDA walk-through
`ifdef SEQ_EARLY_END_EN
    st1 = '{1, 2, 3, 0, 1};
    cw1 = '{16'h1408, 16'h4800, 16'h1200, 16'h4004, 16'h1408};
`else
    st1 = '{1, 2, 3, 4, 0};
    cw1 = '{16'h1408, 16'h4800, 16'h1200, 16'h0000, 16'h4004};
`endif
    for (int i = 0; i < 5; i++)
      tick_x(1'b1, 4'h1, 1'b0, 1'b0, "lda_seq", st1[i], cw1[i], 2'b00, 1'b0);

    // SUB setting both flags, then taken JZ
    do_reset();
    tick_x(1'b1, 4'h3, 1'b0, 1'b0, "sub_t1", 1, 16'h1408, 2'b00, 1'b0);
    tick_x(1'b1, 4'h3, 1'b0, 1'b0, "sub_t2", 2, 16'h4800, 2'b00, 1'b0);
    tick_x(1'b1, 4'h0, 1'b0, 1'b0, "sub_t3", 3, 16'h1020, 2'b00, 1'b0);
    tick_x(1'b1, 4'h0, 1'b0, 1'b0, "sub_t4", 4, 16'h02C1, 2'b00, 1'b0);
    tick_x(1'b1, 4'h0, 1'b1, 1'b1, "sub_flags", 0, 16'h4004, 2'b11, 1'b0);
    tick_x(1'b1, 4'h8, 1'b0, 1'b0, "jz_t1", 1, 16'h1408, 2'b11, 1'b0);
    tick_x(1'b1, 4'h8, 1'b0, 1'b0, "jz_taken", 2, 16'h0802, 2'b11, 1'b0);

    // run back to T0, then clear in the middle of ADD
    for (int i = 0; i < MAX_STEPS && m_step != 0; i++) tick(1'b1, 4'h0, 1'b0, 1'b0);
    tick_x(1'b1, 4'h2, 1'b0, 1'b0, "add_t1", 1, 16'h1408, 2'b11, 1'b0);
    tick_x(1'b1, 4'h2, 1'b0, 1'b0, "add_t2", 2, 16'h4800, 2'b11, 1'b0);
    tick_x(1'b1, 4'h0, 1'b0, 1'b0, "add_t3", 3, 16'h1020, 2'b11, 1'b0);
    do_reset();

    // untaken JC
    tick_x(1'b1, 4'h7, 1'b0, 1'b0, "jc_t1", 1, 16'h1408, 2'b00, 1'b0);
`ifdef SEQ_EARLY_END_EN
    tick_x(1'b1, 4'h7, 1'b0, 1'b0, "jc_skip", 0, 16'h4004, 2'b00, 1'b0);
`else
    tick_x(1'b1, 4'h7, 1'b0, 1'b0, "jc_t2", 2, 16'h0000, 2'b00, 1'b0);
    tick_x(1'b1, 4'h0, 1'b0, 1'b0, "jc_t3", 3, 16'h0000, 2'b00, 1'b0);
    tick_x(1'b1, 4'h0, 1'b0, 1'b0, "jc_t4", 4, 16'h0000, 2'b00, 1'b0);
    tick_x(1'b1, 4'h0, 1'b0, 1'b0, "jc_wrap", 0, 16'h4004, 2'b00, 1'b0);
`endif

    // HLT freezes until clr
    do_reset();
    tick_x(1'b1, 4'hF, 1'b0, 1'b0, "hlt_t1", 1, 16'h1408, 2'b00, 1'b0);
    tick_x(1'b1, 4'hF, 1'b0, 1'b0, "hlt_t2", 2, 16'h8000, 2'b00, 1'b1);
    for (int i = 0; i < 10; i++)
      tick_x(1'b1, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
             "hlt_freeze", 2, 16'h8000, 2'b00, 1'b1);
    do_reset();
    tick_x(1'b1, 4'h0, 1'b0, 1'b0, "hlt_resume", 1, 16'h1408, 2'b00, 1'b0);

    // step_en low: nothing moves, no opcode or flag capture
    do_reset();
    tick_x(1'b1, 4'h2, 1'b0, 1'b0, "hold_t1", 1, 16'h1408, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++)
      tick_x(1'b0, 4'($urandom_range(15)), 1'b1, 1'b1, "hold_at_t1", 1, 16'h1408, 2'b00, 1'b0);
    tick_x(1'b1, 4'h2, 1'b0, 1'b0, "hold_add_t2", 2, 16'h4800, 2'b00, 1'b0);
    tick_x(1'b1, 4'h0, 1'b0, 1'b0, "hold_add_t3", 3, 16'h1020, 2'b00, 1'b0);
    tick_x(1'b1, 4'h0, 1'b0, 1'b0, "hold_add_t4", 4, 16'h0281, 2'b00, 1'b0);
    for (int i = 0; i < 20; i++)
      tick_x(1'b0, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
             "hold_at_t4", 4, 16'h0281, 2'b00, 1'b0);
    tick_x(1'b1, 4'h0, 1'b1, 1'b0, "hold_flags", 0, 16'h4004, 2'b10, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 3 || (m_halt && $urandom_range(99) < 20))
        do_reset();
      else
        tick(1'($urandom_range(99) < 75), 4'($urandom_range(15)),
             1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
